// File: rtl/div_pkg.sv
// Shared types and constants for the time-shared divider front end.
package div_pkg;

    localparam int unsigned DIV_WIDTH   = 16;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned DONE_CNT_W  = 16;
    localparam int unsigned DBZ_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOT = '1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // One-hot select vector for a two-requester index.
    function automatic logic [1:0] idx_onehot(input logic idx);
        return (idx == REQ1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/divider_comb.sv
// Purely combinational unsigned integer divider.
module divider_comb #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] rem
);

    // Quotient/remainder; a zero divisor yields all-ones and the dividend.
    always_comb begin
        y   = '1;
        rem = a;
        if (b != '0) begin
            y   = a / b;
            rem = a % b;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: ptr picks the winner only when both request.
module rr_arb2
    import div_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    // Winner selection.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = REQ0;
        if (req == 2'b11) begin
            gnt_idx = ptr;
        end else if (req[1]) begin
            gnt_idx = REQ1;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Two-requester, round-robin front end sharing one combinational divider.
// Optional per-requester completion / divide-by-zero counters: DIV_SHARE_STATS_EN.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WIDTH      = DIV_WIDTH,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_y,
    output logic [WIDTH-1:0]     rsp_rem,
    output logic                 rsp_dbz,
    output logic                 busy
`ifdef DIV_SHARE_STATS_EN
    ,
    output logic [DONE_CNT_W-1:0] done_cnt0,
    output logic [DONE_CNT_W-1:0] done_cnt1,
    output logic [DBZ_CNT_W-1:0]  dbz_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYC - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   op_a, op_a_nxt;
    logic [WIDTH-1:0]   op_b, op_b_nxt;
    logic               grant, grant_nxt;
    logic               rr_ptr, rr_ptr_nxt;
    logic [1:0]         rsp_valid_nxt;
    logic [WIDTH-1:0]   rsp_y_nxt, rsp_rem_nxt;
    logic               rsp_dbz_nxt;
    logic               busy_nxt;

    logic               gnt_idx, gnt_vld;
    logic [WIDTH-1:0]   div_y, div_rem;
    logic               op_dbz;

    rr_arb2 u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    divider_comb #(.WIDTH(WIDTH)) u_div (
        .a   (op_a),
        .b   (op_b),
        .y   (div_y),
        .rem (div_rem)
    );

    assign op_dbz = (op_b == '0);

    // Next-state, operand latch, result capture and accept strobe.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_a_nxt      = op_a;
        op_b_nxt      = op_b;
        grant_nxt     = grant;
        rr_ptr_nxt    = rr_ptr;
        rsp_valid_nxt = rsp_valid;
        rsp_y_nxt     = rsp_y;
        rsp_rem_nxt   = rsp_rem;
        rsp_dbz_nxt   = rsp_dbz;
        req_ready     = '0;

        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    req_ready = idx_onehot(gnt_idx);
                    op_a_nxt  = (gnt_idx == REQ1) ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                    op_b_nxt  = (gnt_idx == REQ1) ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                    grant_nxt = gnt_idx;
                    cnt_nxt   = '0;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_CNT) begin
                    rsp_dbz_nxt   = op_dbz;
                    rsp_y_nxt     = op_dbz ? '1 : div_y;
                    rsp_rem_nxt   = op_dbz ? op_a : div_rem;
                    rsp_valid_nxt = idx_onehot(grant);
                    cnt_nxt       = '0;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready[grant]) begin
                    rsp_valid_nxt = '0;
                    rr_ptr_nxt    = ~grant;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                rsp_valid_nxt = '0;
                state_nxt     = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            grant     <= REQ0;
            rr_ptr    <= REQ0;
            rsp_valid <= '0;
            rsp_y     <= '0;
            rsp_rem   <= '0;
            rsp_dbz   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_y     <= rsp_y_nxt;
            rsp_rem   <= rsp_rem_nxt;
            rsp_dbz   <= rsp_dbz_nxt;
            busy      <= busy_nxt;
        end
    end

`ifdef DIV_SHARE_STATS_EN
    logic resp_done;
    logic dbz_capture;

    assign resp_done   = (state == RESP) && rsp_ready[grant];
    assign dbz_capture = (state == CALC) && (cnt == LAST_CNT) && op_dbz;

    // Completion counters wrap; divide-by-zero counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt0 <= '0;
            done_cnt1 <= '0;
            dbz_cnt   <= '0;
        end else begin
            if (resp_done && (grant == REQ0)) begin
                done_cnt0 <= done_cnt0 + DONE_CNT_W'(1);
            end
            if (resp_done && (grant == REQ1)) begin
                done_cnt1 <= done_cnt1 + DONE_CNT_W'(1);
            end
            if (dbz_capture && (dbz_cnt != '1)) begin
                dbz_cnt <= dbz_cnt + DBZ_CNT_W'(1);
            end
        end
    end
`endif

endmodule
